instr_register_ctrl: RTL and testbench

Write-arbiter and issue sequencer for the instruction register. Two requesters compete for the single write port; granted instructions are stored at an auto-incrementing `write_pointer`. Stored words are issued in order to one consumer via a valid/ready handshake driven by `read_pointer`. The block sits between the stimulus/producer side and the `instr_register` DUT and owns all of that DUT's control and address inputs.

---
 rtl/instr_register_pkg.sv | 42 ++++
 rtl/instr_register_arbiter.sv | 86 ++++++++
 rtl/instr_register_ctrl.sv | 166 ++++++++++++++++
 tb/tb_instr_register_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its write/issue controller.
//   opcode_t      : 4-bit instruction opcode
//   operand_t     : 32-bit signed operand
//   address_t     : 5-bit register slot address (32 slots)
//   instruction_t : packed {opcode, operand_a, operand_b} as stored in a slot
//   CTRL_DEPTH    : slot count seen by the controller, equals 2**$bits(address_t)
//   grant_t       : write-port arbitration result
// -----------------------------------------------------------------------------
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [4:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int CTRL_DEPTH = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } grant_t;

endpackage

// File: rtl/instr_register_arbiter.sv
// -----------------------------------------------------------------------------
// instr_register_arbiter
// Two-way grant logic for the single write port of the instruction register.
// Configuration macro: INSTR_REGISTER_CTRL_RR_EN
//   defined   : round-robin, the requester not granted last wins contention;
//               a one-bit last-grant register is kept (reset points at req1
//               so that req0 wins the first contention)
//   undefined : fixed priority, req0 always wins; no state, no clock ports
// Ports:
//   clk_i, reset_n_i : clock and async active-low reset (round-robin only)
//   canWrite_i       : the write port may accept a word this cycle
//   req0Valid_i      : requester 0 has a word
//   req1Valid_i      : requester 1 has a word
//   grant_o          : which requester (if any) is granted this cycle
// -----------------------------------------------------------------------------
module instr_register_arbiter
  import instr_register_pkg::*;
(
`ifdef INSTR_REGISTER_CTRL_RR_EN
  input  logic   clk_i,
  input  logic   reset_n_i,
`endif
  input  logic   canWrite_i,
  input  logic   req0Valid_i,
  input  logic   req1Valid_i,
  output grant_t grant_o
);

  grant_t grantD;

`ifdef INSTR_REGISTER_CTRL_RR_EN
  logic lastGrant_q;
  logic lastGrant_d;

  // Round-robin pick: with both requesters waiting, the one that did not
  // win most recently gets the port; a lone requester always wins.
  always_comb begin
    grantD = GNT_NONE;
    if (canWrite_i) begin
      if (req0Valid_i && req1Valid_i) begin
        grantD = lastGrant_q ? GNT_REQ0 : GNT_REQ1;
      end else if (req0Valid_i) begin
        grantD = GNT_REQ0;
      end else if (req1Valid_i) begin
        grantD = GNT_REQ1;
      end
    end
  end

  // Remember the most recent winner; cycles without a grant (including
  // flush, which blocks all grants) leave the history untouched.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grantD == GNT_REQ0) begin
      lastGrant_d = 1'b0;
    end else if (grantD == GNT_REQ1) begin
      lastGrant_d = 1'b1;
    end
  end

  // Last-grant flop; reset value 1 means "req1 went last" so req0 wins first.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end
`else
  // Fixed priority: req0 wins every contention, req1 only gets the port
  // when req0 is idle.
  always_comb begin
    grantD = GNT_NONE;
    if (canWrite_i) begin
      if (req0Valid_i) begin
        grantD = GNT_REQ0;
      end else if (req1Valid_i) begin
        grantD = GNT_REQ1;
      end
    end
  end
`endif

  assign grant_o = grantD;

endmodule

// File: rtl/instr_register_ctrl.sv
// -----------------------------------------------------------------------------
// instr_register_ctrl
// Write arbiter and in-order issue sequencer for instr_register. Two
// requesters share the register's write port; accepted words are stored at an
// auto-incrementing write pointer and issued in order to one consumer through
// a valid/ready handshake addressed by the read pointer.
// Configuration macro: INSTR_REGISTER_CTRL_RR_EN (round-robin arbitration when
// defined, fixed priority to requester 0 otherwise).
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   flush                : synchronous clear of pointers and occupancy
//   reqN_valid/ready     : requester N handshake (N = 0, 1)
//   reqN_opcode/operand_*: requester N write data
//   load_en              : write strobe to instr_register
//   opcode, operand_a/b  : write data muxed from the granted requester
//   write_pointer        : slot written on load_en
//   read_pointer         : slot presented on instruction_word
//   instruction_word     : combinational read data from instr_register
//   issue_valid/ready    : consumer handshake, issue_word is the read data
//   count, full, empty   : occupancy
// -----------------------------------------------------------------------------
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int DEPTH = CTRL_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  opcode_t                req0_opcode,
  input  opcode_t                req1_opcode,
  input  operand_t               req0_operand_a,
  input  operand_t               req0_operand_b,
  input  operand_t               req1_operand_a,
  input  operand_t               req1_operand_b,
  output logic                   load_en,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               write_pointer,
  output address_t               read_pointer,
  input  instruction_t           instruction_word,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output instruction_t           issue_word,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  address_t         writePointer_q;
  address_t         writePointer_d;
  address_t         readPointer_q;
  address_t         readPointer_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic   canWrite;
  logic   handshake;
  grant_t grant;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // Writes are judged on the pre-edge occupancy, so a full register stays
  // closed even when a slot is being freed in the same cycle. Holding reset
  // also closes the port so nothing is granted while the block is cleared.
  assign canWrite = reset_n && !full && !flush;

  instr_register_arbiter u_arbiter (
`ifdef INSTR_REGISTER_CTRL_RR_EN
    .clk_i       (clk),
    .reset_n_i   (reset_n),
`endif
    .canWrite_i  (canWrite),
    .req0Valid_i (req0_valid),
    .req1Valid_i (req1_valid),
    .grant_o     (grant)
  );

  assign req0_ready = (grant == GNT_REQ0);
  assign req1_ready = (grant == GNT_REQ1);
  assign load_en    = (grant != GNT_NONE);

  // Write data follows the granted requester; requester 0 drives the bus
  // whenever nobody is granted.
  always_comb begin
    opcode    = req0_opcode;
    operand_a = req0_operand_a;
    operand_b = req0_operand_b;
    if (grant == GNT_REQ1) begin
      opcode    = req1_opcode;
      operand_a = req1_operand_a;
      operand_b = req1_operand_b;
    end
  end

  // Issue side: no bypass from the write port, a word becomes visible only
  // after it has been stored, so an empty register never offers data.
  assign issue_valid = reset_n && !empty && !flush;
  assign handshake   = issue_valid && issue_ready;
  assign issue_word  = instruction_word;

  // Pointer and occupancy update. Pointers wrap naturally at the address
  // width. A simultaneous write and issue leaves the count unchanged.
  always_comb begin
    writePointer_d = writePointer_q;
    readPointer_d  = readPointer_q;
    count_d        = count_q;
    if (flush) begin
      writePointer_d = '0;
      readPointer_d  = '0;
      count_d        = '0;
    end else begin
      if (load_en) begin
        writePointer_d = writePointer_q + address_t'(1);
      end
      if (handshake) begin
        readPointer_d = readPointer_q + address_t'(1);
      end
      case ({load_en, handshake})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared asynchronously so reset takes effect at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      writePointer_q <= '0;
      readPointer_q  <= '0;
      count_q        <= '0;
    end else begin
      writePointer_q <= writePointer_d;
      readPointer_q  <= readPointer_d;
      count_q        <= count_d;
    end
  end

  assign write_pointer = writePointer_q;
  assign read_pointer  = readPointer_q;
  assign count         = count_q;

  // Requesters are expected to hold valid and data while stalled; a
  // requester that withdraws or changes its word is flagged, not repaired.
  instruction_t req0Payload;
  instruction_t req1Payload;
  assign req0Payload = {req0_opcode, req0_operand_a, req0_operand_b};
  assign req1Payload = {req1_opcode, req1_operand_a, req1_operand_b};

  req0HoldCheck: assert property (@(posedge clk) disable iff (!reset_n)
    (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0Payload)));

  req1HoldCheck: assert property (@(posedge clk) disable iff (!reset_n)
    (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1Payload)));

endmodule

// File: tb/tb_instr_register_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_register_ctrl
// Self-checking bench for instr_register_ctrl. Provides a behavioural model of
// instr_register (written on load_en, read combinationally at read_pointer),
// a directed vector table, hand-written corner sequences and a randomized run
// compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_instr_register_ctrl;
  import instr_register_pkg::*;

  localparam int DEPTH = CTRL_DEPTH;
`ifdef INSTR_REGISTER_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic                   req0_valid, req1_valid;
  logic                   req0_ready, req1_ready;
  opcode_t                req0_opcode, req1_opcode;
  operand_t               req0_operand_a, req0_operand_b;
  operand_t               req1_operand_a, req1_operand_b;
  logic                   load_en;
  opcode_t                opcode;
  operand_t               operand_a, operand_b;
  address_t               write_pointer, read_pointer;
  instruction_t           instruction_word;
  logic                   issue_valid;
  logic                   issue_ready;
  instruction_t           issue_word;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_register_ctrl #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .req0_valid       (req0_valid),
    .req1_valid       (req1_valid),
    .req0_ready       (req0_ready),
    .req1_ready       (req1_ready),
    .req0_opcode      (req0_opcode),
    .req1_opcode      (req1_opcode),
    .req0_operand_a   (req0_operand_a),
    .req0_operand_b   (req0_operand_b),
    .req1_operand_a   (req1_operand_a),
    .req1_operand_b   (req1_operand_b),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_word       (issue_word),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  // Behavioural instruction register sitting behind the controller.
  instruction_t regFile [DEPTH];
  always @(posedge clk) begin
    if (load_en) regFile[write_pointer] <= {opcode, operand_a, operand_b};
  end
  assign instruction_word = regFile[read_pointer];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic         r0v, r1v, ir, fl;
    instruction_t r0w, r1w;
    logic         expR0Rdy, expR1Rdy, expLoad, expIValid;
    instruction_t expWord;
    int           expCount, expWp, expRp;
  } vec_t;

  vec_t vecs[9];
  instruction_t nopWord;

  function automatic instruction_t mk(opcode_t o, int a, int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = a;
    w.op_b = b;
    return w;
  endfunction

  function automatic instruction_t randWord();
    instruction_t w;
    w.opc  = opcode_t'(4'($urandom_range(0, 7)));
    w.op_a = $urandom;
    w.op_b = $urandom;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0v, input logic r1v, input logic ir,
                               input logic fl, input instruction_t w0,
                               input instruction_t w1);
    req0_valid     = r0v;
    req1_valid     = r1v;
    issue_ready    = ir;
    flush          = fl;
    req0_opcode    = w0.opc;
    req0_operand_a = w0.op_a;
    req0_operand_b = w0.op_b;
    req1_opcode    = w1.opc;
    req1_operand_a = w1.op_a;
    req1_operand_b = w1.op_b;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic checkState(input string tag, input int expCount, input int expWp,
                            input int expRp);
    checkOutput({tag, " count"}, count, expCount);
    checkOutput({tag, " write_pointer"}, write_pointer, expWp);
    checkOutput({tag, " read_pointer"}, read_pointer, expRp);
  endtask

  initial begin
    instruction_t w0, w1;
    instruction_t q[$];
    int   wpM, rpM, lastWin, win, seq;
    logic p0, p1, fl, ir, canW, expIV;
    int   reqPct, irPct;
    logic expSeq [4];

    nopWord = mk(ZERO, 0, 0);

    //            r0v   r1v   ir    fl    r0w               r1w                rdy0  rdy1  load  ivld  word              cnt wp rp
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(ADD, 5, 3),    nopWord,           1'b1, 1'b0, 1'b1, 1'b0, nopWord,          1, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, nopWord,          nopWord,           1'b0, 1'b0, 1'b0, 1'b1, mk(ADD, 5, 3),    1, 1, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, nopWord,          nopWord,           1'b0, 1'b0, 1'b0, 1'b1, mk(ADD, 5, 3),    0, 1, 1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, nopWord,          nopWord,           1'b0, 1'b0, 1'b0, 1'b0, nopWord,          0, 1, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, nopWord,          mk(SUB, 9, 4),     1'b0, 1'b1, 1'b1, 1'b0, nopWord,          1, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(MULT, 2, 7),   nopWord,           1'b1, 1'b0, 1'b1, 1'b1, mk(SUB, 9, 4),    1, 3, 2};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, nopWord,          nopWord,           1'b0, 1'b0, 1'b0, 1'b1, mk(MULT, 2, 7),   0, 3, 3};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, nopWord,          mk(PASSA, 1, 1),   1'b0, 1'b0, 1'b0, 1'b0, nopWord,          0, 0, 0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, nopWord,          mk(PASSA, 1, 1),   1'b0, 1'b1, 1'b1, 1'b0, nopWord,          1, 1, 0};

    // Reset values, observed while reset is still asserted.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);
    #2;
    $display("[TB] reset state");
    checkState("reset", 0, 0, 0);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset full", full, 0);
    checkOutput("reset issue_valid", issue_valid, 0);
    checkOutput("reset load_en", load_en, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table, one cycle per row.
    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].r0v, vecs[i].r1v, vecs[i].ir, vecs[i].fl, vecs[i].r0w, vecs[i].r1w);
      #1;
      checkOutput($sformatf("vec%0d req0_ready", i), req0_ready, vecs[i].expR0Rdy);
      checkOutput($sformatf("vec%0d req1_ready", i), req1_ready, vecs[i].expR1Rdy);
      checkOutput($sformatf("vec%0d load_en", i), load_en, vecs[i].expLoad);
      checkOutput($sformatf("vec%0d issue_valid", i), issue_valid, vecs[i].expIValid);
      if (vecs[i].expIValid)
        checkOutput($sformatf("vec%0d issue_word", i), issue_word, vecs[i].expWord);
      if (vecs[i].expLoad)
        checkOutput($sformatf("vec%0d write data", i), {opcode, operand_a, operand_b},
                    vecs[i].expR1Rdy ? vecs[i].r1w : vecs[i].r0w);
      @(posedge clk);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expWp, vecs[i].expRp);
      checkOutput($sformatf("vec%0d empty", i), empty, vecs[i].expCount == 0);
      @(negedge clk);
    end

    // Contention: both requesters valid for four cycles.
    $display("[TB] contention");
    doReset();
    for (int k = 0; k < 4; k++) expSeq[k] = RR ? k[0] : 1'b0;
    seq = 0;
    w0 = mk(ADD, 100, 0);
    w1 = mk(SUB, 200, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, w0, w1);
      #1;
      checkOutput($sformatf("contend%0d req0_ready", k), req0_ready, !expSeq[k]);
      checkOutput($sformatf("contend%0d req1_ready", k), req1_ready, expSeq[k]);
      @(posedge clk);
      seq++;
      if (expSeq[k]) w1 = mk(SUB, 200 + seq, seq);
      else           w0 = mk(ADD, 100 + seq, seq);
      @(negedge clk);
    end
    checkOutput("contend count", count, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, w0, w1);
    #1;
    checkOutput("contend lone req1_ready", req1_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);

    // Fill to full, wrap, blocked write with a simultaneous handshake.
    $display("[TB] full and wrap");
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, mk(ADD, i, 2 * i), nopWord);
      #1;
      if (!req0_ready) checkOutput($sformatf("fill%0d req0_ready", i), req0_ready, 1);
      @(negedge clk);
    end
    checkOutput("full flag", full, 1);
    checkState("full", DEPTH, 0, 0);
    w0 = mk(SUB, 77, 88);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, w0, nopWord);
    #1;
    checkOutput("full 33rd req0_ready", req0_ready, 0);
    checkOutput("full 33rd load_en", load_en, 0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, w0, nopWord);
    #1;
    checkOutput("full+hs req0_ready", req0_ready, 0);
    checkOutput("full+hs issue_valid", issue_valid, 1);
    checkOutput("full+hs issue_word", issue_word, mk(ADD, 0, 0));
    @(posedge clk);
    #1;
    checkState("full+hs", DEPTH - 1, 0, 1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, w0, nopWord);
    #1;
    checkOutput("refill req0_ready", req0_ready, 1);
    checkOutput("refill write_pointer", write_pointer, 0);
    @(posedge clk);
    #1;
    checkState("refill", DEPTH, 1, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);

    // Flush with a pending write and a ready consumer.
    $display("[TB] flush");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, mk(MULT, i, i), nopWord);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, nopWord, nopWord);
      @(negedge clk);
    end
    checkState("preflush", 7, 10, 3);
    w1 = mk(DIV, 3, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, nopWord, w1);
    #1;
    checkOutput("flush req1_ready", req1_ready, 0);
    checkOutput("flush load_en", load_en, 0);
    checkOutput("flush issue_valid", issue_valid, 0);
    @(posedge clk);
    #1;
    checkState("postflush", 0, 0, 0);
    checkOutput("postflush empty", empty, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, nopWord, w1);
    #1;
    checkOutput("postflush req1_ready", req1_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);

    // Randomized traffic against a queue model of the stored words.
    $display("[TB] random traffic");
    doReset();
    q.delete();
    wpM = 0;
    rpM = 0;
    lastWin = 1;
    p0 = 1'b0;
    p1 = 1'b0;
    w0 = nopWord;
    w1 = nopWord;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reqPct = (cyc < 300) ? 80 : 40;
      irPct  = (cyc < 300) ? 30 : 80;
      if (!p0 && $urandom_range(0, 99) < reqPct) begin p0 = 1'b1; w0 = randWord(); end
      if (!p1 && $urandom_range(0, 99) < reqPct) begin p1 = 1'b1; w1 = randWord(); end
      fl = ($urandom_range(0, 99) < 2);
      ir = ($urandom_range(0, 99) < irPct);
      applyStimulus(p0, p1, ir, fl, w0, w1);
      #1;
      canW  = (q.size() < DEPTH) && !fl;
      expIV = (q.size() > 0) && !fl;
      win = -1;
      if (canW) begin
        if (p0 && p1)  win = RR ? (lastWin == 0 ? 1 : 0) : 0;
        else if (p0)   win = 0;
        else if (p1)   win = 1;
      end
      checkOutput("rand req0_ready", req0_ready, win == 0);
      checkOutput("rand req1_ready", req1_ready, win == 1);
      checkOutput("rand load_en", load_en, win >= 0);
      checkOutput("rand issue_valid", issue_valid, expIV);
      if (expIV && ir) checkOutput("rand issue_word", issue_word, q[0]);
      if (fl) begin
        q.delete();
        wpM = 0;
        rpM = 0;
      end else begin
        if (expIV && ir) begin
          void'(q.pop_front());
          rpM = (rpM + 1) % DEPTH;
        end
        if (win >= 0) begin
          q.push_back(win == 0 ? w0 : w1);
          wpM = (wpM + 1) % DEPTH;
          lastWin = win;
          if (win == 0) p0 = 1'b0;
          else          p1 = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      checkState("rand", q.size(), wpM, rpM);
      checkOutput("rand full", full, q.size() == DEPTH);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of continuous traffic.
    $display("[TB] reset mid-stream");
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    issue_ready = 1'b1;
    flush       = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkState("midreset", 0, 0, 0);
    checkOutput("midreset load_en", load_en, 0);
    checkOutput("midreset req0_ready", req0_ready, 0);
    checkOutput("midreset req1_ready", req1_ready, 0);
    checkOutput("midreset issue_valid", issue_valid, 0);
    checkOutput("midreset empty", empty, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("release req0_ready", req0_ready, 1);
    checkOutput("release req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checkOutput("release req1 follow-up", req1_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, nopWord, nopWord);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
